// File: rtl/noc_pkg.sv
// Shared definitions for the router receive port: flit width, flit type codes
// and the packet framing state.
package noc_pkg;

    localparam int FLIT_W = 20;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        FRM_IDLE  = 1'b0,
        FRM_INPKT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/noc_rx_fifo.sv
// First-word fall-through FIFO (DEPTH x WIDTH) for the receive port.
// A push at a full FIFO is accepted only when the head leaves on the same edge.
module noc_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/noc_credit_rx_port.sv
// Router input port facing a PE: buffers flits, returns one credit per dequeue and
// checks packet framing. Optional sticky overflow flag under NOC_RX_OVF_CHECK_EN.
module noc_credit_rx_port #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 20
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic [FLIT_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              ovf_err
);

    import noc_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic [1:0]    head_type;
    logic          co_reg;
    logic          frame_err_reg;
    frame_state_t  state_reg;
    logic          unused_fifo;

    noc_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .RST     (RST),
        .wr_en   (in_valid),
        .wr_data (datain),
        .rd_en   (out_ready),
        .rd_data (dataout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign unused_fifo = ^{fifo_count, fifo_full};
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign head_type   = dataout[FLIT_W-1 -: 2];

    // Framing is judged on the flit leaving the port; the flit itself is never altered.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg     <= FRM_IDLE;
            frame_err_reg <= 1'b0;
            co_reg        <= 1'b0;
        end else begin
            co_reg        <= pop;
            frame_err_reg <= 1'b0;
            if (pop) begin
                case (state_reg)
                    FRM_IDLE: begin
                        case (head_type)
                            FLIT_HEAD:   state_reg <= FRM_INPKT;
                            FLIT_SINGLE: state_reg <= FRM_IDLE;
                            default:     frame_err_reg <= 1'b1;
                        endcase
                    end
                    default: begin
                        case (head_type)
                            FLIT_BODY: state_reg <= FRM_INPKT;
                            FLIT_TAIL: state_reg <= FRM_IDLE;
                            FLIT_HEAD: frame_err_reg <= 1'b1;
                            default: begin
                                frame_err_reg <= 1'b1;
                                state_reg     <= FRM_IDLE;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign co        = co_reg;
    assign frame_err = frame_err_reg;

`ifdef NOC_RX_OVF_CHECK_EN
    logic ovf_reg;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ovf_reg <= 1'b0;
        end else if (in_valid && fifo_full && !pop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf_err = ovf_reg;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Directed bench for noc_credit_rx_port: reset, latency, fill/drain, full with
// simultaneous push/pop, overflow drop and framing errors.
module tb_noc_credit_rx_port;

    localparam logic [19:0] F_HEAD   = 20'h40000;
    localparam logic [19:0] F_BODY   = 20'h00000;
    localparam logic [19:0] F_TAIL   = 20'h80000;
    localparam logic [19:0] F_SINGLE = 20'hC0000;

`ifdef NOC_RX_OVF_CHECK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        RST       = 1'b0;
    logic [19:0] datain    = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        co;
    logic [19:0] dataout;
    logic        out_valid;
    logic        frame_err;
    logic        ovf_err;

    int vectors     = 0;
    int miscompares = 0;

    noc_credit_rx_port #(.DEPTH(4), .FLIT_W(20)) dut (
        .clk       (clk),
        .RST       (RST),
        .datain    (datain),
        .in_valid  (in_valid),
        .co        (co),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic push_flit(input logic [19:0] d);
        in_valid = 1'b1;
        datain   = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, co, frame_err, ovf_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs got valid/co/ferr/ovf=%b want 0000",
                     {out_valid, co, frame_err, ovf_err});
        end
        RST = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        push_flit(F_HEAD | 20'h11);
        push_flit(F_BODY | 20'h22);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        datain    = F_TAIL | 20'h33;
        #2 RST = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, co, frame_err, ovf_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_midtraffic got valid/co/ferr/ovf=%b want 0000",
                     {out_valid, co, frame_err, ovf_err});
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        RST       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || co !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_empty[%0d] got valid=%b co=%b want 0 0", i, out_valid, co);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1;
        push_flit(F_HEAD | 20'h1);
        vectors++;
        if (out_valid !== 1'b1 || dataout !== 20'h40001 || co !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_first got valid=%b data=%h co=%b want 1 40001 0", out_valid, dataout, co);
        end
        @(negedge clk);
        vectors++;
        if (co !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_credit got co=%b valid=%b want 1 0", co, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (co !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_credit_pulse got co=%b want 0", co);
        end
        out_ready = 1'b0;
        $display("test_latency done");
    endtask

    task automatic test_fill_drain();
        logic [19:0] fl [4];
        int co_cnt = 0;
        fl[0] = F_SINGLE | 20'h0A1;
        fl[1] = F_SINGLE | 20'h0B2;
        fl[2] = F_SINGLE | 20'h0C3;
        fl[3] = F_SINGLE | 20'h0D4;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_flit(fl[i]);
            vectors++;
            if (co !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL fill[%0d] got co=%b valid=%b want 0 1", i, co, out_valid);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || dataout !== fl[i]) begin
                miscompares++;
                $display("FAIL drain[%0d] got valid=%b data=%h want 1 %h", i, out_valid, dataout, fl[i]);
            end
            @(negedge clk);
            co_cnt += int'(co);
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty got valid=%b want 0", out_valid);
        end
        @(negedge clk);
        co_cnt += int'(co);
        vectors++;
        if (co_cnt != 4) begin
            miscompares++;
            $display("FAIL drain_credits got %0d want 4", co_cnt);
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_full_simul();
        logic [19:0] fl [5];
        int co_cnt = 0;
        for (int i = 0; i < 5; i++) fl[i] = F_SINGLE | 20'(16 * i + 5);
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(fl[i]);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        datain    = fl[4];
        vectors++;
        if (dataout !== fl[0]) begin
            miscompares++;
            $display("FAIL simul_head got %h want %h", dataout, fl[0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        co_cnt += int'(co);
        vectors++;
        if (co !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_credit got co=%b want 1", co);
        end
        for (int i = 1; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || dataout !== fl[i]) begin
                miscompares++;
                $display("FAIL simul_drain[%0d] got valid=%b data=%h want 1 %h", i, out_valid, dataout, fl[i]);
            end
            @(negedge clk);
            co_cnt += int'(co);
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || co_cnt != 5) begin
            miscompares++;
            $display("FAIL simul_end got valid=%b credits=%0d want 0 5", out_valid, co_cnt);
        end
        $display("test_full_simul done");
    endtask

    task automatic test_overflow();
        logic [19:0] fl [4];
        for (int i = 0; i < 4; i++) fl[i] = F_SINGLE | 20'(32 * i + 7);
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(fl[i]);
        vectors++;
        if (ovf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_before got %b want 0", ovf_err);
        end
        push_flit(F_SINGLE | 20'h999);
        vectors++;
        if (ovf_err !== EXP_OVF) begin
            miscompares++;
            $display("FAIL ovf_flag got %b want %b", ovf_err, EXP_OVF);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || dataout !== fl[i]) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d] got valid=%b data=%h want 1 %h", i, out_valid, dataout, fl[i]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || ovf_err !== EXP_OVF) begin
            miscompares++;
            $display("FAIL ovf_end got valid=%b ovf=%b want 0 %b", out_valid, ovf_err, EXP_OVF);
        end
        $display("test_overflow done");
    endtask

    task automatic test_framing();
        logic [19:0] fl [4];
        logic [3:0]  exp_err;
        fl[0] = F_HEAD   | 20'h1;
        fl[1] = F_BODY   | 20'h2;
        fl[2] = F_SINGLE | 20'h3;
        fl[3] = F_TAIL   | 20'h4;
        exp_err = 4'b1100;
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(fl[i]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dataout !== fl[i]) begin
                miscompares++;
                $display("FAIL frame_data[%0d] got %h want %h", i, dataout, fl[i]);
            end
            @(negedge clk);
            vectors++;
            if (frame_err !== exp_err[i]) begin
                miscompares++;
                $display("FAIL frame_err[%0d] got %b want %b", i, frame_err, exp_err[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_pulse got %b want 0", frame_err);
        end
        push_flit(F_HEAD | 20'h5);
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0 || co !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_idle_head got ferr=%b co=%b want 0 1", frame_err, co);
        end
        out_ready = 1'b0;
        $display("test_framing done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_full_simul();
        test_overflow();
        test_framing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
